// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
// Default geometry: 32-bit addresses and words, 8 sets, 27-bit tags.
// Entry layout is {valid, tag, data}; lines are a single word.
package dcache_pkg;

   localparam int DC_ADDR_WIDTH  = 32;
   localparam int DC_DATA_WIDTH  = 32;
   localparam int DC_SET_BITS    = 3;
   localparam int DC_OFFSET_BITS = 2;
   localparam int DC_TAG_BITS    = DC_ADDR_WIDTH - DC_SET_BITS - DC_OFFSET_BITS;
   localparam int DC_NUM_SETS    = 1 << DC_SET_BITS;

   typedef struct packed {
      logic                     valid;
      logic [DC_TAG_BITS-1:0]   tag;
      logic [DC_DATA_WIDTH-1:0] data;
   } cache_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_WRITE  = 2'd2
   } state_t;

endpackage

// File: rtl/dcache_array.sv
// Cache storage: one entry per set, combinational read by index, one write port.
// Latency: read is same-cycle, write lands at the clock edge.
// No backpressure; reset clears every valid bit and overrides a coincident write.
module dcache_array
   import dcache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DC_SET_BITS-1:0] i_rd_idx,
   output cache_entry_t           o_rd_entry,
   input  logic                   i_wr_en,
   input  logic [DC_SET_BITS-1:0] i_wr_idx,
   input  cache_entry_t           i_wr_entry
);

   cache_entry_t r_entries [DC_NUM_SETS];

   // Asynchronous lookup port
   assign o_rd_entry = r_entries[i_rd_idx];

   // Single write port; reset invalidates all lines (tag/data left as-is)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DC_NUM_SETS; i++) begin
            r_entries[i].valid <= 1'b0;
         end
      end else if (i_wr_en) begin
         r_entries[i_wr_idx] <= i_wr_entry;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through D-cache controller: same-cycle lookup, refill on read miss, write-allocate + write-through.
// Latency: read hit 0 added cycles; read miss / write stall from lookup until the mem_ack cycle.
// Backpressure: cpu_stall holds the CPU; memory paces via single-cycle mem_ack. Optional DCACHE_STATS_EN adds hit/miss counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
   parameter int DATA_WIDTH = DC_DATA_WIDTH,
   parameter int SET_BITS   = DC_SET_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_read_en,
   input  logic                  cpu_write_en,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_write_data,
   output logic [DATA_WIDTH-1:0] cpu_read_data,
   output logic                  cpu_stall,
   output logic                  hit,
   output logic                  miss,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
  ,output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   state_t                  r_state;
   logic                    r_mem_req;
   logic                    r_mem_we;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic [DATA_WIDTH-1:0]   r_mem_wdata;

   logic [SET_BITS-1:0]     w_idx;
   logic [DC_TAG_BITS-1:0]  w_tag;
   logic [SET_BITS-1:0]     w_pend_idx;
   logic [DC_TAG_BITS-1:0]  w_pend_tag;
   logic [ADDR_WIDTH-1:0]   w_word_addr;
   cache_entry_t            w_rd_entry;
   logic                    w_lookup_hit;
   logic                    w_req;
   logic                    w_wr_en;
   logic [SET_BITS-1:0]     w_wr_idx;
   cache_entry_t            w_wr_entry;
   logic                    w_unused_offset;

   // Byte offset never selects anything: lines are one word
   assign w_unused_offset = ^cpu_addr[1:0];

   assign w_idx        = cpu_addr[SET_BITS+1:2];
   assign w_tag        = cpu_addr[ADDR_WIDTH-1:SET_BITS+2];
   assign w_word_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
   assign w_pend_idx   = r_mem_addr[SET_BITS+1:2];
   assign w_pend_tag   = r_mem_addr[ADDR_WIDTH-1:SET_BITS+2];
   assign w_lookup_hit = w_rd_entry.valid && (w_rd_entry.tag == w_tag);
   assign w_req        = cpu_read_en | cpu_write_en;

   dcache_array u_array (
      .clk        (clk),
      .rst        (rst),
      .i_rd_idx   (w_idx),
      .o_rd_entry (w_rd_entry),
      .i_wr_en    (w_wr_en),
      .i_wr_idx   (w_wr_idx),
      .i_wr_entry (w_wr_entry)
   );

   // Array write source: CPU store at the lookup edge, or refill data on ack
   always_comb begin
      w_wr_en    = 1'b0;
      w_wr_idx   = w_idx;
      w_wr_entry = {1'b1, w_tag, cpu_write_data};
      if (r_state == ST_IDLE && cpu_write_en) begin
         w_wr_en = 1'b1;
      end else if (r_state == ST_REFILL && mem_ack) begin
         w_wr_en    = 1'b1;
         w_wr_idx   = w_pend_idx;
         w_wr_entry = {1'b1, w_pend_tag, mem_read_data};
      end
   end

   // CPU-facing lookup results, stall and read-data bypass
   always_comb begin
      hit           = 1'b0;
      miss          = 1'b0;
      cpu_stall     = 1'b0;
      cpu_read_data = '0;
      case (r_state)
         ST_IDLE: begin
            hit       = w_req & w_lookup_hit;
            miss      = w_req & ~w_lookup_hit;
            cpu_stall = cpu_write_en | (cpu_read_en & ~w_lookup_hit);
            if (cpu_read_en && !cpu_write_en && w_lookup_hit) begin
               cpu_read_data = w_rd_entry.data;
            end
         end
         ST_REFILL: begin
            cpu_stall = ~mem_ack;
            if (mem_ack) begin
               cpu_read_data = mem_read_data;
            end
         end
         ST_WRITE: begin
            cpu_stall = ~mem_ack;
         end
         default: begin
            cpu_stall = 1'b0;
         end
      endcase
   end

   // Miss/write FSM with registered memory-side request, address and data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cpu_write_en) begin
                  r_mem_addr  <= w_word_addr;
                  r_mem_wdata <= cpu_write_data;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_state     <= ST_WRITE;
               end else if (cpu_read_en && !w_lookup_hit) begin
                  r_mem_addr  <= w_word_addr;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_state     <= ST_REFILL;
               end
            end
            ST_REFILL, ST_WRITE: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req        = r_mem_req;
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_write_data = r_mem_wdata;

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   // Saturating lookup statistics; hit/miss only pulse in IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (hit && r_hit_count != '1) begin
            r_hit_count <= r_hit_count + 32'd1;
         end
         if (miss && r_miss_count != '1) begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus a randomized run.
// Expected values come from a set-indexed line model and a word-addressed main-memory model.
// Memory acks are generated by the bench with a per-access latency.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_read_en = 1'b0;
   logic        cpu_write_en = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_write_data = '0;
   logic [31:0] cpu_read_data;
   logic        cpu_stall;
   logic        hit;
   logic        miss;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data = '0;
   logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   dcache_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_read_en    (cpu_read_en),
      .cpu_write_en   (cpu_write_en),
      .cpu_addr       (cpu_addr),
      .cpu_write_data (cpu_write_data),
      .cpu_read_data  (cpu_read_data),
      .cpu_stall      (cpu_stall),
      .hit            (hit),
      .miss           (miss),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_ack        (mem_ack)
`ifdef DCACHE_STATS_EN
     ,.hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference models ----------------
   logic [31:0] mainmem [logic [31:0]];
   bit          m_valid [8];
   logic [26:0] m_tag   [8];
   logic [31:0] m_data  [8];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] w;
      w = word_of(a);
      if (mainmem.exists(w)) return mainmem[w];
      return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int s;
      s = int'(a[4:2]);
      return m_valid[s] && (m_tag[s] == a[31:5]);
   endfunction

   // Apply the architectural effect of one completed access to the models
   task automatic model_commit(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      int s;
      s = int'(a[4:2]);
      if (wr) begin
         m_valid[s] = 1'b1; m_tag[s] = a[31:5]; m_data[s] = wd;
         mainmem[word_of(a)] = wd;
      end else if (rd && !model_hit(a)) begin
         m_valid[s] = 1'b1; m_tag[s] = a[31:5]; m_data[s] = mem_rd(a);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1; cpu_read_en = 1'b0; cpu_write_en = 1'b0; mem_ack = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Drive one CPU access and act as main memory answering after 'lat' cycles of mem_req.
   // o_stall = number of sampled cycles with cpu_stall high, or -1 if the bound expired.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input int lat,
                            output logic o_hit, output logic o_miss, output logic [31:0] o_rdata,
                            output int o_stall, output logic o_req, output logic o_we,
                            output logic [31:0] o_maddr, output logic [31:0] o_mwdata, output logic o_bad);
      int n;
      bit done;
      cpu_read_en = rd; cpu_write_en = wr; cpu_addr = a; cpu_write_data = wd; mem_ack = 1'b0;
      o_req = 1'b0; o_we = 1'b0; o_maddr = '0; o_mwdata = '0; o_bad = 1'b0; o_stall = 0; n = 0;
      @(negedge clk);
      o_hit = hit; o_miss = miss; o_rdata = cpu_read_data;
      done = !cpu_stall;
      if (!done) o_stall = 1;
      for (int c = 0; c < 60 && !done; c++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         mem_read_data = $urandom;
         if (mem_req) begin
            if (!o_req) begin
               o_req = 1'b1; o_we = mem_we; o_maddr = mem_addr; o_mwdata = mem_write_data;
            end else if (mem_we !== o_we || mem_addr !== o_maddr || mem_write_data !== o_mwdata) begin
               o_bad = 1'b1;
            end
            if (n == lat) begin
               mem_ack = 1'b1;
               mem_read_data = mem_rd(mem_addr);
            end
            n++;
         end
         @(negedge clk);
         if (hit || miss) o_bad = 1'b1;
         if (cpu_stall) o_stall++;
         else begin done = 1'b1; o_rdata = cpu_read_data; end
      end
      if (!done) o_stall = -1;
      @(posedge clk); #1;
      cpu_read_en = 1'b0; cpu_write_en = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      if (mem_req) o_bad = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      n_checks++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_write_data); end
      n_checks++; if ({hit, miss, cpu_stall} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {hit, miss, cpu_stall}); end
      n_checks++; if (cpu_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", cpu_read_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_read_miss_hit();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      mainmem[32'h40] = 32'hDEAD_BEEF;
      do_access(1, 0, 32'h40, 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
      model_commit(1, 0, 32'h40, 0);
      n_checks++; if ({h, m} !== 2'b01) begin n_fail++; $display("FAIL rmiss_hitmiss got=%b exp=01", {h, m}); end
      n_checks++; if (rq !== 1'b1 || we !== 1'b0 || ma !== 32'h40) begin n_fail++; $display("FAIL rmiss_req got req=%b we=%b addr=%h exp 1/0/40", rq, we, ma); end
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rmiss_data got=%h exp=deadbeef", rd); end
      n_checks++; if (st !== 2) begin n_fail++; $display("FAIL rmiss_stall got=%0d exp=2", st); end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rmiss_protocol got=%b exp=0", bad); end
      do_access(1, 0, 32'h40, 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
      n_checks++; if ({h, m} !== 2'b10) begin n_fail++; $display("FAIL rhit_hitmiss got=%b exp=10", {h, m}); end
      n_checks++; if (rd !== 32'hDEAD_BEEF || st !== 0 || rq !== 1'b0) begin n_fail++; $display("FAIL rhit got data=%h stall=%0d req=%b exp deadbeef/0/0", rd, st, rq); end
   endtask

   task automatic test_write();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      do_access(0, 1, 32'h44, 32'h1234_5678, 3, h, m, rd, st, rq, we, ma, mw, bad);
      model_commit(0, 1, 32'h44, 32'h1234_5678);
      n_checks++; if (rq !== 1'b1 || we !== 1'b1 || ma !== 32'h44 || mw !== 32'h1234_5678) begin n_fail++; $display("FAIL write_req got req=%b we=%b addr=%h data=%h exp 1/1/44/12345678", rq, we, ma, mw); end
      n_checks++; if (st !== 4) begin n_fail++; $display("FAIL write_stall got=%0d exp=4", st); end
      n_checks++; if ({h, m} !== 2'b01 || bad !== 1'b0) begin n_fail++; $display("FAIL write_flags got hm=%b bad=%b exp 01/0", {h, m}, bad); end
      do_access(1, 0, 32'h44, 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
      n_checks++; if (h !== 1'b1 || rd !== 32'h1234_5678 || rq !== 1'b0 || st !== 0) begin n_fail++; $display("FAIL write_readback got hit=%b data=%h req=%b stall=%0d exp 1/12345678/0/0", h, rd, rq, st); end
   endtask

   task automatic test_conflict();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      logic [31:0] seq [3];
      seq[0] = 32'h40; seq[1] = 32'h140; seq[2] = 32'h40;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_access(1, 0, seq[i], 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
         model_commit(1, 0, seq[i], 0);
         n_checks++; if (m !== 1'b1 || h !== 1'b0 || rq !== 1'b1) begin n_fail++; $display("FAIL conflict_miss%0d got hit=%b miss=%b req=%b exp 0/1/1", i, h, m, rq); end
         n_checks++; if (rd !== mem_rd(seq[i])) begin n_fail++; $display("FAIL conflict_data%0d got=%h exp=%h", i, rd, mem_rd(seq[i])); end
      end
   endtask

   task automatic test_both_enables();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      do_access(1, 1, 32'h48, 32'hCAFE_F00D, 2, h, m, rd, st, rq, we, ma, mw, bad);
      model_commit(1, 1, 32'h48, 32'hCAFE_F00D);
      n_checks++; if (rq !== 1'b1 || we !== 1'b1 || ma !== 32'h48 || mw !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL both_req got req=%b we=%b addr=%h data=%h exp 1/1/48/cafef00d", rq, we, ma, mw); end
      n_checks++; if (st !== 3 || bad !== 1'b0) begin n_fail++; $display("FAIL both_stall got stall=%0d bad=%b exp 3/0", st, bad); end
      do_access(1, 0, 32'h48, 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
      n_checks++; if (h !== 1'b1 || rd !== 32'hCAFE_F00D || rq !== 1'b0) begin n_fail++; $display("FAIL both_readback got hit=%b data=%h req=%b exp 1/cafef00d/0", h, rd, rq); end
   endtask

   task automatic test_idle_ack();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      @(posedge clk); #1; mem_ack = 1'b1; mem_read_data = 32'hBAD0_BAD0;
      @(negedge clk);
      n_checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL idle_ack got req=%b stall=%b exp 0/0", mem_req, cpu_stall); end
      @(posedge clk); #1; mem_ack = 1'b0;
      do_access(1, 0, 32'h48, 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
      n_checks++; if (h !== 1'b1 || rd !== 32'hCAFE_F00D || st !== 0) begin n_fail++; $display("FAIL idle_ack_after got hit=%b data=%h stall=%0d exp 1/cafef00d/0", h, rd, st); end
   endtask

   // Reset arriving while a refill or a write is outstanding
   task automatic test_reset_mid_txn();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      for (int k = 0; k < 2; k++) begin
         logic [31:0] a;
         a = (k == 0) ? 32'h80 : 32'hC0;
         apply_reset();
         cpu_read_en = (k == 0); cpu_write_en = (k == 1); cpu_addr = a; cpu_write_data = 32'h7777_0000;
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++; if (mem_req !== 1'b1 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL abort%0d_pending got req=%b stall=%b exp 1/1", k, mem_req, cpu_stall); end
         @(posedge clk); #1; rst = 1'b1;
         @(posedge clk); #1; rst = 1'b0; cpu_read_en = 1'b0; cpu_write_en = 1'b0;
         model_reset();
         @(negedge clk);
         n_checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL abort%0d_idle got req=%b stall=%b exp 0/0", k, mem_req, cpu_stall); end
         @(posedge clk); #1;
         do_access(1, 0, a, 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
         model_commit(1, 0, a, 0);
         n_checks++; if (m !== 1'b1 || rd !== mem_rd(a)) begin n_fail++; $display("FAIL abort%0d_reread got miss=%b data=%h exp 1/%h", k, m, rd, mem_rd(a)); end
      end
   endtask

   task automatic test_random();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      apply_reset();
      for (int i = 0; i < 150; i++) begin
         int op, lat; logic r, w; logic [31:0] a, wd, exp_rd; bit ph, tx;
         op  = $urandom_range(0, 9);
         r   = (op >= 2 && op <= 6) || op == 9;
         w   = (op >= 7);
         a   = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         wd  = $urandom;
         lat = $urandom_range(0, 3);
         ph  = model_hit(a);
         tx  = w || (r && !ph);
         exp_rd = (r && !w) ? (ph ? m_data[int'(a[4:2])] : mem_rd(a)) : 32'h0;
         do_access(r, w, a, wd, lat, h, m, rd, st, rq, we, ma, mw, bad);
         n_checks++; if (h !== ((r | w) & ph)) begin n_fail++; $display("FAIL rnd_hit i=%0d got=%b exp=%b", i, h, (r | w) & ph); end
         n_checks++; if (m !== ((r | w) & !ph)) begin n_fail++; $display("FAIL rnd_miss i=%0d got=%b exp=%b", i, m, (r | w) & !ph); end
         n_checks++; if (st !== (tx ? lat + 1 : 0)) begin n_fail++; $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, st, tx ? lat + 1 : 0); end
         n_checks++; if (rq !== tx) begin n_fail++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, rq, tx); end
         if (r && !w) begin
            n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, rd, exp_rd); end
         end
         if (tx) begin
            n_checks++; if (we !== w || ma !== word_of(a)) begin n_fail++; $display("FAIL rnd_memreq i=%0d got we=%b addr=%h exp %b/%h", i, we, ma, w, word_of(a)); end
            if (w) begin
               n_checks++; if (mw !== wd) begin n_fail++; $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, mw, wd); end
            end
         end
         n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rnd_protocol i=%0d got=%b exp=0", i, bad); end
         model_commit(r, w, a, wd);
      end
   endtask

`ifdef DCACHE_STATS_EN
   task automatic test_stats();
      logic h, m, rq, we, bad; logic [31:0] rd, ma, mw; int st;
      logic [31:0] seq [5];
      seq[0] = 32'h40; seq[1] = 32'h44; seq[2] = 32'h40; seq[3] = 32'h44; seq[4] = 32'h40;
      apply_reset();
      @(negedge clk);
      n_checks++; if (hit_count !== 0 || miss_count !== 0) begin n_fail++; $display("FAIL stats_reset got h=%0d m=%0d exp 0/0", hit_count, miss_count); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         do_access(1, 0, seq[i], 0, 1, h, m, rd, st, rq, we, ma, mw, bad);
         model_commit(1, 0, seq[i], 0);
      end
      @(negedge clk);
      n_checks++; if (hit_count !== 3 || miss_count !== 2) begin n_fail++; $display("FAIL stats_count got h=%0d m=%0d exp 3/2", hit_count, miss_count); end
      apply_reset();
      @(negedge clk);
      n_checks++; if (hit_count !== 0 || miss_count !== 0) begin n_fail++; $display("FAIL stats_clear got h=%0d m=%0d exp 0/0", hit_count, miss_count); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_read_miss_hit();
      test_write();
      test_both_enables();
      test_idle_ack();
      test_conflict();
      test_reset_mid_txn();
`ifdef DCACHE_STATS_EN
      test_stats();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
